// File: rtl/ripple_pkg.sv
// rtl/ripple_pkg.sv - shared constants and FSM encoding for ripple counter capture
package ripple_pkg;

   // Capture FSM: UNPRIMED accepts the first stable value unchecked, TRACK step-checks
   typedef enum logic {
      ST_UNPRIMED = 1'b0,
      ST_TRACK    = 1'b1
   } state_e;

   localparam int DEF_WIDTH         = 4;
   localparam int DEF_STABLE_CYCLES = 2;
   localparam int DEF_WRAP_W        = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - per-bit two-flop synchronizer, async active-high reset to 0
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;

   // Two back-to-back flops per bit; bits are not assumed to arrive together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/ripple_count_capture.sv
// rtl/ripple_count_capture.sv - sync, settle-filter, step-check and hand off a ripple down counter
module ripple_count_capture
   import ripple_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int WRAP_W        = DEF_WRAP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  cnt_in,
   output logic [WIDTH-1:0]  cnt_out,
   output logic              cnt_valid,
   input  logic              cnt_ready,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              glitch_err,
   output logic              overrun
);

   localparam int               SW       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_CYCLES - 1);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] s2;

   sync_2ff #(.W(WIDTH)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (cnt_in),
      .q_o (s2)
   );

   // cand_vld_q keeps the reset value of s2 from masquerading as an already-loaded
   // candidate, so a value is only accepted after it has really been seen at s2
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [SW-1:0]    stab_q, stab_d;
   logic             cand_vld_q, cand_vld_d;

   // Stability filter next state: reload on change, otherwise count up to the threshold and hold
   always_comb begin
      cand_d     = cand_q;
      stab_d     = stab_q;
      cand_vld_d = 1'b1;
      if (!cand_vld_q || (s2 != cand_q)) begin
         cand_d = s2;
         stab_d = '0;
      end else if (stab_q != STAB_MAX) begin
         stab_d = stab_q + SW'(1);
      end
   end

   // Filter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q     <= '0;
         stab_q     <= '0;
         cand_vld_q <= 1'b0;
      end else begin
         cand_q     <= cand_d;
         stab_q     <= stab_d;
         cand_vld_q <= cand_vld_d;
      end
   end

   state_e            state_q;
   logic [WIDTH-1:0]  acc_q;
   logic [WIDTH-1:0]  cnt_out_q;
   logic              cnt_valid_q;
   logic              wrap_pulse_q;
   logic [WRAP_W-1:0] wrap_count_q;
   logic              glitch_q;
   logic              overrun_q;

   logic eligible;
   logic accept;
   logic is_wrap;
   logic bad_step;

   assign eligible = cand_vld_q && (s2 == cand_q) && (stab_q == STAB_MAX);
   assign accept   = eligible && ((state_q == ST_UNPRIMED) || (cand_q != acc_q));
   // acc-1 covers the wrap too, since 0-1 is all ones
   assign is_wrap  = (state_q == ST_TRACK) && (acc_q == '0) && (cand_q == ALL_ONES);
   assign bad_step = (state_q == ST_TRACK) && (cand_q != (acc_q - WIDTH'(1)));

   // Capture FSM with step check, wrap counter and one-entry holding register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_UNPRIMED;
         acc_q        <= '0;
         cnt_out_q    <= '0;
         cnt_valid_q  <= 1'b0;
         wrap_pulse_q <= 1'b0;
         wrap_count_q <= '0;
         glitch_q     <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         wrap_pulse_q <= 1'b0;
         if (accept) begin
            state_q     <= ST_TRACK;
            acc_q       <= cand_q;
            cnt_out_q   <= cand_q;
            cnt_valid_q <= 1'b1;
            if (is_wrap) begin
               wrap_pulse_q <= 1'b1;
               wrap_count_q <= wrap_count_q + WRAP_W'(1);
            end
            if (bad_step) begin
               glitch_q <= 1'b1;
            end
            // A simultaneous ready means the old value left this cycle, so nothing is lost
            if (cnt_valid_q && !cnt_ready) begin
               overrun_q <= 1'b1;
            end
         end else if (cnt_valid_q && cnt_ready) begin
            cnt_valid_q <= 1'b0;
         end
      end
   end

   assign cnt_out    = cnt_out_q;
   assign cnt_valid  = cnt_valid_q;
   assign wrap_pulse = wrap_pulse_q;
   assign wrap_count = wrap_count_q;
   assign glitch_err = glitch_q;
   assign overrun    = overrun_q;

endmodule
